dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory slave for a CPU memory stage.
// Each request is served after a fixed number of wait states and answered
// with a one-cycle ready strobe. Misaligned or out-of-range accesses are
// answered with err and have no effect on memory.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_load_ok;
  logic [31:0] r_mem_q;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_enter_resp;
  logic [31:0] w_acc_addr;
  logic        w_acc_we;
  logic [31:0] w_acc_wdata;
  logic        w_fault;
  logic [IW-1:0] w_idx;
  logic        w_do_write;
  logic        w_do_read;

  // With zero wait states the access happens on the accepting edge, so the
  // live request fields are used; otherwise the latched copy is used.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && req;
    w_enter_resp = ((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                   (w_accept && NO_WAIT);
    w_acc_addr   = (r_state == S_IDLE) ? addr  : r_addr;
    w_acc_we     = (r_state == S_IDLE) ? we    : r_we;
    w_acc_wdata  = (r_state == S_IDLE) ? wdata : r_wdata;
    w_fault      = (w_acc_addr[1:0] != 2'b00) ||
                   ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH));
    w_idx        = w_acc_addr[IW+1:2];
    w_do_write   = w_enter_resp && w_acc_we && !w_fault;
    w_do_read    = w_enter_resp && !w_acc_we && !w_fault;
  end

  // Memory array with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
    if (w_do_read) begin
      r_mem_q <= r_mem[w_idx];
    end
  end

  // Transaction FSM, request latch, wait counter and response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 32'd0;
      r_we      <= 1'b0;
      r_wdata   <= 32'd0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      // err is only ever set on the edge entering RESP, so it is high for
      // the single response cycle and low otherwise.
      r_err <= w_enter_resp ? w_fault : 1'b0;
      if (w_enter_resp) begin
        r_load_ok <= w_do_read;
      end
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Load data is forced to zero for stores, faults and after reset.
  assign rdata = r_load_ok ? r_mem_q : 32'd0;
  assign ready = (r_state == S_RESP);
  assign busy  = (r_state != S_IDLE);
  assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and
// one with none, each checked against a word-array reference model.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_w2 = 1'b0, we_w2 = 1'b0;
  logic [31:0] addr_w2 = '0, wdata_w2 = '0;
  logic [31:0] rdata_w2;
  logic        ready_w2, busy_w2, err_w2;

  logic        req_w0 = 1'b0, we_w0 = 1'b0;
  logic [31:0] addr_w0 = '0, wdata_w0 = '0;
  logic [31:0] rdata_w0;
  logic        ready_w0, busy_w0, err_w0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .req(req_w2), .we(we_w2), .addr(addr_w2),
    .wdata(wdata_w2), .rdata(rdata_w2), .ready(ready_w2), .busy(busy_w2),
    .err(err_w2)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req(req_w0), .we(we_w0), .addr(addr_w0),
    .wdata(wdata_w0), .rdata(rdata_w0), .ready(ready_w0), .busy(busy_w0),
    .err(err_w0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Reference model: word-addressed array, faults leave it untouched.
  function automatic exp_t model(input int s, input logic w, input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t e;
    int   idx;
    idx = int'(a[31:2]);
    if (a[1:0] != 2'b00 || a[31:2] >= 30'd1024) begin
      e.rdata = 32'd0; e.err = 1'b1; e.chk_data = 1'b1;
    end else if (w) begin
      m_mem[s][idx]   = d;
      m_known[s][idx] = 1'b1;
      e.rdata = 32'd0; e.err = 1'b0; e.chk_data = 1'b1;
    end else begin
      e.rdata = m_mem[s][idx]; e.err = 1'b0; e.chk_data = m_known[s][idx];
    end
    return e;
  endfunction

  // Issue one transaction, hold req until ready, check latency in edges
  // counted from the edge after which req was driven.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n;
    bit   got;
    e = model(s, w, a, d);
    if (s == 1) q1.push_back(e); else q0.push_back(e);
    @(posedge clk); #1;
    if (s == 1) begin req_w2 = 1'b1; we_w2 = w; addr_w2 = a; wdata_w2 = d; end
    else        begin req_w0 = 1'b1; we_w0 = w; addr_w0 = a; wdata_w0 = d; end
    n = 0; got = 1'b0;
    repeat (40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if ((s == 1 && ready_w2) || (s == 0 && ready_w0)) begin got = 1'b1; break; end
    end
    if (s == 1) req_w2 = 1'b0; else req_w0 = 1'b0;
    if (!got) begin
      errors++; checks++;
      $display("FAIL ready_timeout dut=%0d addr=%h actual=none required=ready", s, a);
    end else begin
      $display("txn dut=%0d we=%0d addr=%h wdata=%h latency=%0d", s, w, a, d, n);
      chk($sformatf("latency_d%0d", s), 32'(n), (s == 1) ? 32'd3 : 32'd1);
    end
  endtask

  // Monitor for the two-wait-state instance.
  always @(negedge clk) begin : mon_w2
    exp_t e;
    if (ready_w2) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_ready_w2 actual=1 required=0");
      end else begin
        e = q1.pop_front();
        chk("err_w2", {31'd0, err_w2}, {31'd0, e.err});
        if (e.chk_data) chk("rdata_w2", rdata_w2, e.rdata);
      end
    end else if (rst && err_w2) begin
      chk("err_idle_w2", {31'd0, err_w2}, 32'd0);
    end
  end

  // Monitor for the zero-wait instance; busy without ready would mean WAIT.
  always @(negedge clk) begin : mon_w0
    exp_t e;
    if (ready_w0) begin
      if (q0.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_ready_w0 actual=1 required=0");
      end else begin
        e = q0.pop_front();
        chk("err_w0", {31'd0, err_w0}, {31'd0, e.err});
        if (e.chk_data) chk("rdata_w0", rdata_w0, e.rdata);
      end
    end else begin
      if (err_w0)  chk("err_idle_w0", {31'd0, err_w0}, 32'd0);
      if (busy_w0) chk("busy_wait_w0", {31'd0, busy_w0}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   got;
    int   r;
    logic [31:0] a;

    // Reset state.
    #12;
    chk("rst_ready_w2", {31'd0, ready_w2}, 32'd0);
    chk("rst_busy_w2",  {31'd0, busy_w2},  32'd0);
    chk("rst_err_w2",   {31'd0, err_w2},   32'd0);
    chk("rst_rdata_w2", rdata_w2, 32'd0);
    chk("rst_ready_w0", {31'd0, ready_w0}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Store then load.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(1, 1'b0, 32'h10, 32'h0);
    // Misaligned.
    txn(1, 1'b0, 32'h13, 32'h0);
    txn(1, 1'b1, 32'h20, 32'hA5A50008);
    txn(1, 1'b1, 32'h22, 32'hFFFFFFFF);
    txn(1, 1'b0, 32'h20, 32'h0);
    // Out of range (would alias word 0 if the range check were skipped).
    txn(1, 1'b1, 32'h0, 32'h0BADF00D);
    txn(1, 1'b1, 32'h1000, 32'h11111111);
    txn(1, 1'b0, 32'h0, 32'h0);
    txn(1, 1'b1, 32'hFFC, 32'hCAFE0FFC);
    txn(1, 1'b0, 32'hFFC, 32'h0);

    // Held request: three loads get accepted over the window.
    repeat (3) begin
      e = model(1, 1'b0, 32'h10, 32'h0);
      q1.push_back(e);
    end
    @(posedge clk); #1;
    req_w2 = 1'b1; we_w2 = 1'b0; addr_w2 = 32'h10;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      $display("held cycle=%0d ready=%0d busy=%0d", k, ready_w2, busy_w2);
      chk($sformatf("held_ready_c%0d", k), {31'd0, ready_w2}, {31'd0, (k == 3 || k == 7)});
      chk($sformatf("held_busy_c%0d", k),  {31'd0, busy_w2},  {31'd0, !(k == 4 || k == 8)});
    end
    req_w2 = 1'b0;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready_w2) begin got = 1'b1; break; end
    end
    chk("held_third_ready", {31'd0, got}, 32'd1);

    // Reset during WAIT aborts a store.
    txn(1, 1'b1, 32'h40, 32'h12345678);
    txn(1, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    req_w2 = 1'b1; we_w2 = 1'b1; addr_w2 = 32'h40; wdata_w2 = 32'h55;
    @(posedge clk); #2;
    rst = 1'b0; req_w2 = 1'b0;
    #1;
    $display("reset mid-store ready=%0d busy=%0d err=%0d rdata=%h", ready_w2, busy_w2, err_w2, rdata_w2);
    chk("abort_ready", {31'd0, ready_w2}, 32'd0);
    chk("abort_busy",  {31'd0, busy_w2},  32'd0);
    chk("abort_err",   {31'd0, err_w2},   32'd0);
    chk("abort_rdata", rdata_w2, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    txn(1, 1'b0, 32'h40, 32'h0);

    // Zero wait states.
    txn(0, 1'b1, 32'h10, 32'h600DF00D);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(0, 1'b0, 32'h13, 32'h0);
    txn(0, 1'b1, 32'h2000, 32'h77777777);

    // Randomized traffic on both instances.
    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 32'($urandom_range(0, 31)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'($urandom_range(1024, 4095)) << 2;
      else             a = 32'hFFC;
      txn((i % 3 == 2) ? 0 : 1, 1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
